i2c_init_seq: RTL and testbench

Table-driven sequencer that drives the single-transaction `i2c_control` master. On `start` it walks an external configuration table of register writes, issuing each entry as one `wrreg_req`. After every write it waits out the device write-cycle time and retries NACKed transactions. It sits between system bring-up logic and `i2c_control`, for example to load EEPROM or codec/DDS register images at power-up.

---
 rtl/i2c_seq_pkg.sv | 34 +++
 rtl/i2c_seq_timer.sv | 30 +++
 rtl/i2c_init_seq.sv | 255 +++++++++++++++++++++++++
 tb/tb_i2c_init_seq.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the table-driven I2C init sequencer: FSM states,
// table entry field offsets, the end-of-table marker and the settle-delay
// cycle count calculation.
package i2c_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_DONE,
    S_DELAY,
    S_VERIFY,
    S_VERIFY_WAIT,
    S_DONE,
    S_ERROR
  } state_e;

  // Table entry layout: {device_id, addr_mode, addr, data}
  localparam int ENTRY_W      = 33;
  localparam int ENT_DEV_LSB  = 25;
  localparam int ENT_MODE_BIT = 24;
  localparam int ENT_ADDR_LSB = 8;
  localparam int ENT_DATA_LSB = 0;

  // A device_id of zero terminates the table walk.
  localparam logic [7:0] END_DEVICE_ID = 8'h00;

  // Number of clock cycles spent waiting out the device write cycle.
  function automatic int unsigned calc_dly(input int unsigned clk_freq,
                                           input int unsigned wr_delay_us);
    return (clk_freq / 1_000_000) * wr_delay_us;
  endfunction

endpackage

// File: rtl/i2c_seq_timer.sv
// Loadable down-counter used to time the post-write settle delay.
// expired_o is high whenever the count has reached zero.
module i2c_seq_timer
  import i2c_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 18
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] cnt_q;

  // Load on request, otherwise count down and hold at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/i2c_init_seq.sv
// Table-driven sequencer for the single-transaction i2c_control master.
// Walks a synchronous configuration ROM, issuing one register write per
// entry, waiting out the device write cycle after each and retrying NACKs.
// Optional feature macro I2C_INIT_SEQ_VERIFY_EN: read back every write after
// its settle delay and treat a mismatch or read NACK as a failed attempt.
module i2c_init_seq
  import i2c_seq_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned WR_DELAY_US = 5000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned TBL_AW      = 8
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [TBL_AW-1:0]  err_index,
  output logic [TBL_AW-1:0]  tbl_index,
  input  logic [ENTRY_W-1:0] tbl_entry,
  output logic               wrreg_req,
  output logic               rdreg_req,
  output logic [7:0]         device_id,
  output logic [15:0]        addr,
  output logic               addr_mode,
  output logic [7:0]         wrdata,
  input  logic               RW_Done,
  input  logic               ack,
  input  logic [7:0]         rddata
);

  localparam int unsigned DLY = calc_dly(CLK_FREQ, WR_DELAY_US);
  localparam int unsigned TW  = (DLY > 1) ? $clog2(DLY + 1) : 1;
  // The cycle that loads the timer is not part of DELAY, so load DLY-1.
  localparam logic [TW-1:0] DLY_LOAD = TW'(DLY - 1);
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_e              state_q, state_d;
  logic                fetch_wait_q, fetch_wait_d;
  logic [RW-1:0]       retry_q, retry_d;
  logic                retry_pend_q, retry_pend_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [TBL_AW-1:0]   err_index_q, err_index_d;
  logic [TBL_AW-1:0]   tbl_index_q, tbl_index_d;
  logic [7:0]          dev_q, dev_d;
  logic [15:0]         addr_q, addr_d;
  logic                mode_q, mode_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                timer_load;
  logic                timer_expired;
  logic                advance;

  i2c_seq_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk_i      (Clk),
    .rst_ni     (Rst_n),
    .load_i     (timer_load),
    .load_val_i (DLY_LOAD),
    .expired_o  (timer_expired)
  );

  // State and output registers; reset aborts any walk in progress.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= S_IDLE;
      fetch_wait_q <= 1'b0;
      retry_q      <= '0;
      retry_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_index_q  <= '0;
      tbl_index_q  <= '0;
      dev_q        <= '0;
      addr_q       <= '0;
      mode_q       <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      fetch_wait_q <= fetch_wait_d;
      retry_q      <= retry_d;
      retry_pend_q <= retry_pend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_index_q  <= err_index_d;
      tbl_index_q  <= tbl_index_d;
      dev_q        <= dev_d;
      addr_q       <= addr_d;
      mode_q       <= mode_d;
      wdata_q      <= wdata_d;
    end
  end

  // Next-state logic: fetch, issue, wait, settle, (verify), advance or fail.
  always_comb begin
    state_d      = state_q;
    fetch_wait_d = fetch_wait_q;
    retry_d      = retry_q;
    retry_pend_d = retry_pend_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    err_index_d  = err_index_q;
    tbl_index_d  = tbl_index_q;
    dev_d        = dev_q;
    addr_d       = addr_q;
    mode_d       = mode_q;
    wdata_d      = wdata_q;
    timer_load   = 1'b0;
    advance      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d       = 1'b0;
          error_d      = 1'b0;
          err_index_d  = '0;
          tbl_index_d  = '0;
          retry_d      = '0;
          retry_pend_d = 1'b0;
          busy_d       = 1'b1;
          fetch_wait_d = 1'b1;
          state_d      = S_FETCH;
        end
      end

      S_FETCH: begin
        // First cycle presents the address; the entry is valid on the second.
        if (fetch_wait_q) begin
          fetch_wait_d = 1'b0;
        end else if (tbl_entry[ENT_DEV_LSB +: 8] == END_DEVICE_ID) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          dev_d   = tbl_entry[ENT_DEV_LSB +: 8];
          mode_d  = tbl_entry[ENT_MODE_BIT];
          addr_d  = tbl_entry[ENT_ADDR_LSB +: 16];
          wdata_d = tbl_entry[ENT_DATA_LSB +: 8];
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        if (RW_Done) begin
          if (!ack) begin
            retry_pend_d = 1'b0;
            timer_load   = 1'b1;
            state_d      = S_DELAY;
          end else if (retry_q < RETRY_MAX) begin
            retry_d      = retry_q + 1'b1;
            retry_pend_d = 1'b1;
            timer_load   = 1'b1;
            state_d      = S_DELAY;
          end else begin
            err_index_d = tbl_index_q;
            error_d     = 1'b1;
            busy_d      = 1'b0;
            state_d     = S_ERROR;
          end
        end
      end

      S_DELAY: begin
        if (timer_expired) begin
          if (retry_pend_q) begin
            state_d = S_ISSUE;
          end else begin
`ifdef I2C_INIT_SEQ_VERIFY_EN
            state_d = S_VERIFY;
`else
            advance = 1'b1;
`endif
          end
        end
      end

`ifdef I2C_INIT_SEQ_VERIFY_EN
      S_VERIFY: begin
        state_d = S_VERIFY_WAIT;
      end

      S_VERIFY_WAIT: begin
        if (RW_Done) begin
          if (!ack && (rddata == wdata_q)) begin
            advance = 1'b1;
          end else if (retry_q < RETRY_MAX) begin
            // Readback failed: rewrite the entry straight away.
            retry_d = retry_q + 1'b1;
            state_d = S_ISSUE;
          end else begin
            err_index_d = tbl_index_q;
            error_d     = 1'b1;
            busy_d      = 1'b0;
            state_d     = S_ERROR;
          end
        end
      end
`endif

      S_DONE, S_ERROR: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Move to the next entry, stopping at the top of the table instead of wrapping.
    if (advance) begin
      retry_d = '0;
      if (&tbl_index_q) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end else begin
        tbl_index_d  = tbl_index_q + 1'b1;
        fetch_wait_d = 1'b1;
        state_d      = S_FETCH;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_index = err_index_q;
  assign tbl_index = tbl_index_q;
  assign device_id = dev_q;
  assign addr      = addr_q;
  assign addr_mode = mode_q;
  assign wrdata    = wdata_q;
  assign wrreg_req = (state_q == S_ISSUE);

`ifdef I2C_INIT_SEQ_VERIFY_EN
  assign rdreg_req = (state_q == S_VERIFY);
`else
  assign rdreg_req = 1'b0;
  logic unused_rddata;
  assign unused_rddata = ^rddata;
`endif

endmodule

// File: tb/tb_i2c_init_seq.sv
module tb_i2c_init_seq;

  localparam int CF  = 1_000_000;
  localparam int WD  = 8;
  localparam int MR  = 2;
  localparam int AW  = 3;
  localparam int DLY = 8;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, error;
  logic [AW-1:0] err_index, tbl_index;
  logic [32:0]   tbl_entry;
  logic          wrreg_req, rdreg_req;
  logic [7:0]    device_id;
  logic [15:0]   addr;
  logic          addr_mode;
  logic [7:0]    wrdata;
  logic          RW_Done, ack;
  logic [7:0]    rddata;

  int checks = 0;
  int errors = 0;

  logic [32:0] rom [0:(1<<AW)-1];
  logic [7:0]  mem [0:255];
  int          cyc = 0;
  int          start_cyc = 0;
  int          wr_count = 0, rd_count = 0, wdone_count = 0;
  int          corrupt_idx = -1;
  int          wr_cyc [0:127];
  int          wdone_cyc [0:127];
  logic [7:0]  wr_addr_log [0:127];
  logic [7:0]  wr_dev_log [0:127];
  logic        rsp_pend, rsp_rd, rsp_corrupt;
  int          rsp_cnt;
  logic        overlap = 1'b0;

  i2c_init_seq #(
    .CLK_FREQ    (CF),
    .WR_DELAY_US (WD),
    .MAX_RETRY   (MR),
    .TBL_AW      (AW)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_index (err_index),
    .tbl_index (tbl_index),
    .tbl_entry (tbl_entry),
    .wrreg_req (wrreg_req),
    .rdreg_req (rdreg_req),
    .device_id (device_id),
    .addr      (addr),
    .addr_mode (addr_mode),
    .wrdata    (wrdata),
    .RW_Done   (RW_Done),
    .ack       (ack),
    .rddata    (rddata)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Synchronous table ROM, one cycle latency.
  always @(posedge Clk) tbl_entry <= rom[tbl_index];

  // Behavioural i2c_control + EEPROM: only device A0 acknowledges.
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rsp_pend    <= 1'b0;
      RW_Done     <= 1'b0;
      ack         <= 1'b0;
      rddata      <= 8'h00;
      rsp_cnt     <= 0;
      rsp_rd      <= 1'b0;
      rsp_corrupt <= 1'b0;
    end else begin
      RW_Done <= 1'b0;
      if (RW_Done && !rsp_rd) begin
        wdone_cyc[wdone_count] <= cyc;
        wdone_count <= wdone_count + 1;
      end
      if (wrreg_req || rdreg_req) begin
        if (rsp_pend || (wrreg_req && rdreg_req)) overlap <= 1'b1;
        rsp_pend <= 1'b1;
        rsp_cnt  <= 3;
        rsp_rd   <= rdreg_req;
        if (wrreg_req) begin
          wr_cyc[wr_count]      <= cyc;
          wr_addr_log[wr_count] <= addr[7:0];
          wr_dev_log[wr_count]  <= device_id;
          rsp_corrupt           <= (wr_count == corrupt_idx);
          wr_count              <= wr_count + 1;
        end else begin
          rd_count <= rd_count + 1;
        end
      end else if (rsp_pend) begin
        if (rsp_cnt == 0) begin
          rsp_pend <= 1'b0;
          RW_Done  <= 1'b1;
          ack      <= (device_id != 8'hA0);
          if (rsp_rd) begin
            rddata <= mem[addr[7:0]];
          end else if (device_id == 8'hA0) begin
            mem[addr[7:0]] <= rsp_corrupt ? ~wrdata : wrdata;
          end
        end else begin
          rsp_cnt <= rsp_cnt - 1;
        end
      end
    end
  end

  function automatic logic [32:0] ent(input logic [7:0] d, input logic m,
                                      input logic [15:0] a, input logic [7:0] v);
    return {d, m, a, v};
  endfunction

  task automatic pulse_start();
    @(negedge Clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge Clk);
    end
  endtask

  task automatic load_three();
    rom[0] = ent(8'hA0, 1'b1, 16'h000A, 8'hD1);
    rom[1] = ent(8'hA0, 1'b0, 16'h000B, 8'hD2);
    rom[2] = ent(8'hA0, 1'b0, 16'h000F, 8'hD4);
    rom[3] = ent(8'h00, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if ({busy, done, error, wrreg_req, rdreg_req, err_index, tbl_index,
         device_id, addr, addr_mode, wrdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b error=%b wr=%b rd=%b idx=%0d dev=%h addr=%h, all required 0",
               busy, done, error, wrreg_req, rdreg_req, tbl_index, device_id, addr);
    end
    Rst_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_end_first();
    int base;
    rom[0] = ent(8'h00, 1'b0, 16'h0000, 8'h00);
    base = wr_count;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || tbl_index !== '0) begin
      errors++;
      $display("FAIL end_cycle1: busy=%b tbl_index=%0d, required busy=1 tbl_index=0", busy, tbl_index);
    end
    @(negedge Clk);
    @(negedge Clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL end_cycle3: done=%b busy=%b error=%b, required 1 0 0", done, busy, error);
    end
    checks++;
    if (wr_count - base != 0) begin
      errors++;
      $display("FAIL end_no_write: writes=%0d, required 0", wr_count - base);
    end
  endtask

  task automatic test_three_writes();
    int base, wb;
    bit to;
    load_three();
    base = wr_count;
    wb = wdone_count;
    pulse_start();
    @(negedge Clk);
    @(negedge Clk);
    checks++;
    if (wrreg_req !== 1'b1 || device_id !== 8'hA0 || addr !== 16'h000A ||
        wrdata !== 8'hD1 || addr_mode !== 1'b1) begin
      errors++;
      $display("FAIL first_issue: wr=%b dev=%h addr=%h data=%h mode=%b, required 1 a0 000a d1 1",
               wrreg_req, device_id, addr, wrdata, addr_mode);
    end
    @(negedge Clk);
    checks++;
    if (wrreg_req !== 1'b0) begin
      errors++;
      $display("FAIL issue_pulse_width: wrreg_req=%b at cycle 4, required 0", wrreg_req);
    end
    wait_idle(to);
    checks++;
    if (to || done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL three_done: timeout=%b done=%b error=%b, required 0 1 0", to, done, error);
    end
    checks++;
    if (wr_count - base != 3 || wr_addr_log[base] !== 8'h0A ||
        wr_addr_log[base+1] !== 8'h0B || wr_addr_log[base+2] !== 8'h0F) begin
      errors++;
      $display("FAIL three_order: n=%0d addrs=%h %h %h, required 3 0a 0b 0f",
               wr_count - base, wr_addr_log[base], wr_addr_log[base+1], wr_addr_log[base+2]);
    end
    checks++;
    if (mem[8'h0A] !== 8'hD1 || mem[8'h0B] !== 8'hD2 || mem[8'h0F] !== 8'hD4) begin
      errors++;
      $display("FAIL three_mem: %h %h %h, required d1 d2 d4", mem[8'h0A], mem[8'h0B], mem[8'h0F]);
    end
    checks++;
    if (wr_cyc[base] - start_cyc != 3) begin
      errors++;
      $display("FAIL first_latency: %0d cycles, required 3", wr_cyc[base] - start_cyc);
    end
`ifndef I2C_INIT_SEQ_VERIFY_EN
    checks++;
    if (wr_cyc[base+1] - wdone_cyc[wb] != DLY + 3) begin
      errors++;
      $display("FAIL next_entry_spacing: %0d cycles, required %0d", wr_cyc[base+1] - wdone_cyc[wb], DLY + 3);
    end
`endif
  endtask

  task automatic test_nack_retry();
    int base, wb;
    bit to;
    rom[0] = ent(8'hA0, 1'b0, 16'h0010, 8'h55);
    rom[1] = ent(8'hA2, 1'b0, 16'h0011, 8'h66);
    rom[2] = ent(8'h00, 1'b0, 16'h0000, 8'h00);
    base = wr_count;
    wb = wdone_count;
    pulse_start();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL start_clears_done: done=%b, required 0", done);
    end
    wait_idle(to);
    checks++;
    if (to || error !== 1'b1 || done !== 1'b0 || err_index !== 3'd1) begin
      errors++;
      $display("FAIL nack_error: timeout=%b error=%b done=%b err_index=%0d, required 0 1 0 1",
               to, error, done, err_index);
    end
    checks++;
    if (wr_count - base != 4 || wr_dev_log[base+1] !== 8'hA2 || wr_dev_log[base+3] !== 8'hA2) begin
      errors++;
      $display("FAIL nack_attempts: writes=%0d, required 4 (1 + 3 attempts on A2)", wr_count - base);
    end
    checks++;
    if (wr_cyc[base+2] - wdone_cyc[wb+1] != DLY + 1) begin
      errors++;
      $display("FAIL retry_spacing: %0d cycles, required %0d", wr_cyc[base+2] - wdone_cyc[wb+1], DLY + 1);
    end
  endtask

  task automatic test_start_while_busy();
    int base;
    bit to;
    load_three();
    base = wr_count;
    pulse_start();
    repeat (12) @(negedge Clk);
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_during_walk: busy=%b, required 1", busy);
    end
    wait_idle(to);
    checks++;
    if (to || done !== 1'b1 || wr_count - base != 3 || wr_addr_log[base] !== 8'h0A ||
        wr_addr_log[base+2] !== 8'h0F) begin
      errors++;
      $display("FAIL ignored_start: timeout=%b done=%b writes=%0d, required 0 1 3", to, done, wr_count - base);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    bit to;
    bit seen;
    load_three();
    base = wr_count;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (wr_count != base) begin
        seen = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_mid_issue: no write seen, required one");
    end
    Rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, error, wrreg_req, tbl_index, device_id, addr, addr_mode, wrdata} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: busy=%b dev=%h addr=%h data=%h idx=%0d, all required 0",
               busy, device_id, addr, wrdata, tbl_index);
    end
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    base = wr_count;
    pulse_start();
    wait_idle(to);
    checks++;
    if (to || done !== 1'b1 || wr_count - base != 3 || wr_addr_log[base] !== 8'h0A) begin
      errors++;
      $display("FAIL rerun_after_reset: timeout=%b done=%b writes=%0d first=%h, required 0 1 3 0a",
               to, done, wr_count - base, wr_addr_log[base]);
    end
  endtask

  task automatic test_wrap();
    int base;
    bit to;
    for (int i = 0; i < 8; i++) rom[i] = ent(8'hA0, 1'b0, 16'h0020 + 16'(i), 8'h30 + 8'(i));
    base = wr_count;
    pulse_start();
    wait_idle(to);
    checks++;
    if (to || done !== 1'b1 || error !== 1'b0 || tbl_index !== 3'd7) begin
      errors++;
      $display("FAIL wrap_done: timeout=%b done=%b error=%b tbl_index=%0d, required 0 1 0 7",
               to, done, error, tbl_index);
    end
    checks++;
    if (wr_count - base != 8 || mem[8'h27] !== 8'h37) begin
      errors++;
      $display("FAIL wrap_writes: writes=%0d mem27=%h, required 8 37", wr_count - base, mem[8'h27]);
    end
  endtask

`ifdef I2C_INIT_SEQ_VERIFY_EN
  task automatic test_verify();
    int base, rbase;
    bit to;
    rom[0] = ent(8'hA0, 1'b0, 16'h0040, 8'hD1);
    rom[1] = ent(8'h00, 1'b0, 16'h0000, 8'h00);
    base = wr_count;
    rbase = rd_count;
    corrupt_idx = wr_count;
    pulse_start();
    wait_idle(to);
    checks++;
    if (to || done !== 1'b1 || error !== 1'b0 || mem[8'h40] !== 8'hD1) begin
      errors++;
      $display("FAIL verify_done: timeout=%b done=%b error=%b mem=%h, required 0 1 0 d1",
               to, done, error, mem[8'h40]);
    end
    checks++;
    if (wr_count - base != 2 || rd_count - rbase != 2) begin
      errors++;
      $display("FAIL verify_counts: writes=%0d reads=%0d, required 2 2", wr_count - base, rd_count - rbase);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_end_first();
    test_three_writes();
    test_nack_retry();
    test_start_while_busy();
    test_reset_mid();
    test_wrap();
`ifdef I2C_INIT_SEQ_VERIFY_EN
    test_verify();
`else
    checks++;
    if (rd_count != 0) begin
      errors++;
      $display("FAIL no_readback: reads=%0d, required 0", rd_count);
    end
`endif
    checks++;
    if (overlap !== 1'b0) begin
      errors++;
      $display("FAIL request_overlap: overlap=%b, required 0", overlap);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
